// File: rtl/quadrature_generator.sv
// Quadrature generator: steps quadA/quadB toward a latched target at a programmable period.
// Define QGEN_INDEX_EN to add the revolution counter and index output.
module quadrature_generator #(
    parameter int WIDTH     = 32,
    parameter int PER_WIDTH = 16
`ifdef QGEN_INDEX_EN
    ,
    parameter int CPR       = 4096
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     target,
    input  logic                 target_valid,
    output logic                 target_ready,
    input  logic [PER_WIDTH-1:0] step_period,
    input  logic                 abort,
    output logic                 quadA,
    output logic                 quadB,
    output logic [WIDTH-1:0]     position,
    output logic                 busy,
    output logic                 done
`ifdef QGEN_INDEX_EN
    ,
    output logic                 index
`endif
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     target_l;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     pos_nxt;
    logic [PER_WIDTH-1:0] reload_l;
    logic [PER_WIDTH-1:0] ivl_cnt;
    logic [PER_WIDTH-1:0] eff_reload;
    logic                 accept;
    logic                 tick;
    logic                 at_target;
    logic                 step_down;
    logic                 step_en;
    logic                 done_nxt;

    assign target_ready = (state == S_IDLE);
    assign busy         = (state == S_RUN);
    assign accept       = target_ready && target_valid;

    // A period of 0 behaves like 1, so the reload value saturates at 0.
    assign eff_reload = (step_period == '0) ? '0 : step_period - PER_WIDTH'(1);
    assign tick       = busy && (ivl_cnt == '0);

    // Shortest path in the wrap domain: the sign of the difference picks the direction.
    assign diff      = target_l - position;
    assign at_target = (diff == '0);
    assign step_down = diff[WIDTH-1];
    assign pos_nxt   = step_down ? position - WIDTH'(1) : position + WIDTH'(1);

    always_comb begin
        state_nxt = state;
        step_en   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (target_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (tick) begin
                    if (at_target) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        step_en = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            target_l <= '0;
            reload_l <= '0;
            ivl_cnt  <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (accept) begin
                target_l <= target;
                reload_l <= eff_reload;
                ivl_cnt  <= eff_reload;
            end else if (busy) begin
                ivl_cnt <= (ivl_cnt == '0) ? reload_l : ivl_cnt - PER_WIDTH'(1);
            end
        end
    end

    // AB is the Gray code of position[1:0]: 0->00, 1->10, 2->11, 3->01.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            position <= '0;
            quadA    <= 1'b0;
            quadB    <= 1'b0;
        end else if (step_en) begin
            position <= pos_nxt;
            quadA    <= pos_nxt[1] ^ pos_nxt[0];
            quadB    <= pos_nxt[1];
        end
    end

`ifdef QGEN_INDEX_EN
    localparam int REV_W = (CPR > 1) ? $clog2(CPR) : 1;

    logic [REV_W-1:0] rev;
    logic [REV_W-1:0] rev_nxt;

    always_comb begin
        if (step_down)
            rev_nxt = (rev == '0) ? REV_W'(CPR - 1) : rev - REV_W'(1);
        else
            rev_nxt = (rev == REV_W'(CPR - 1)) ? '0 : rev + REV_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rev   <= '0;
            index <= 1'b1;
        end else if (step_en) begin
            rev   <= rev_nxt;
            index <= (rev_nxt == '0) && !(pos_nxt[1] ^ pos_nxt[0]) && !pos_nxt[1];
        end
    end
`endif

endmodule
